waveshaper_multi: RTL and testbench

//  N-channel successor to the single-voice divider+waveshaper pair. On each sample_now it scales

---
 rtl/waveshaper_pkg.sv | 37 +++
 rtl/frac_divider.sv | 85 ++++++++
 rtl/waveshaper_multi.sv | 168 ++++++++++++++++
 tb/tb_waveshaper_multi.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/waveshaper_pkg.sv
// Shared types, midscale constant and per-mode shaping function for the multi-voice waveshaper.
package waveshaper_pkg;

   localparam int unsigned PKG_SAMPLE_W = 8;
   localparam logic [PKG_SAMPLE_W-1:0] MIDSCALE = {1'b1, {(PKG_SAMPLE_W-1){1'b0}}};

   typedef enum logic [1:0] {
      SQUARE   = 2'b00,
      SAW      = 2'b01,
      TRIANGLE = 2'b10,
      REVSAW   = 2'b11
   } wave_mode_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      DIV,
      SHAPE,
      COMMIT
   } state_t;

   // Map a scaled position onto the selected waveform.
   function automatic logic [PKG_SAMPLE_W-1:0] shape(input wave_mode_t m,
                                                     input logic [PKG_SAMPLE_W-1:0] s);
      logic [PKG_SAMPLE_W-1:0] fold;
      logic [PKG_SAMPLE_W-1:0] r;
      fold = {s[PKG_SAMPLE_W-2:0], 1'b0};
      case (m)
         SQUARE:   r = s[PKG_SAMPLE_W-1] ? '0 : '1;
         SAW:      r = s;
         TRIANGLE: r = s[PKG_SAMPLE_W-1] ? ~fold : fold;
         default:  r = ~s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/frac_divider.sv
// Restoring divider: quot = (count << Q_W) / divider, saturating when the ratio is >= 1.
// Always runs Q_W step cycles after start so callers see a fixed latency.
module frac_divider
   import waveshaper_pkg::*;
#(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned Q_W   = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic [CNT_W-1:0] divider_i,
   output logic [Q_W-1:0]   quot_o,
   output logic             done_c_o
);

   localparam int unsigned STEP_W = $clog2(Q_W);

   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  div_q, div_d;
   logic [Q_W-1:0]    quot_q, quot_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              run_q, run_d;
   logic              sat_q, sat_d;
   logic              sat_c;
   logic [CNT_W:0]    rem_sh_c;

   // Load on start, then one shift/compare/subtract per cycle.
   always_comb begin
      rem_d    = rem_q;
      div_d    = div_q;
      quot_d   = quot_q;
      step_d   = step_q;
      run_d    = run_q;
      sat_d    = sat_q;
      sat_c    = (divider_i == '0) || (count_i >= divider_i);
      rem_sh_c = {rem_q, 1'b0};
      if (start_i) begin
         run_d  = 1'b1;
         step_d = '0;
         rem_d  = count_i;
         div_d  = divider_i;
         sat_d  = sat_c;
         quot_d = sat_c ? '1 : '0;
      end else if (run_q) begin
         step_d = step_q + STEP_W'(1);
         if (step_q == STEP_W'(Q_W-1)) begin
            run_d = 1'b0;
         end
         if (!sat_q) begin
            if (rem_sh_c >= {1'b0, div_q}) begin
               rem_d  = rem_sh_c[CNT_W-1:0] - div_q;
               quot_d = {quot_q[Q_W-2:0], 1'b1};
            end else begin
               rem_d  = rem_sh_c[CNT_W-1:0];
               quot_d = {quot_q[Q_W-2:0], 1'b0};
            end
         end
      end
   end

   // Divider state registers.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         rem_q  <= '0;
         div_q  <= '0;
         quot_q <= '0;
         step_q <= '0;
         run_q  <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         div_q  <= div_d;
         quot_q <= quot_d;
         step_q <= step_d;
         run_q  <= run_d;
         sat_q  <= sat_d;
      end
   end

   assign quot_o   = quot_q;
   assign done_c_o = run_q && (step_q == STEP_W'(Q_W-1));

endmodule

// File: rtl/waveshaper_multi.sv
// N-channel waveshaper: one shared divider walks the channels each frame, results commit atomically.
module waveshaper_multi
   import waveshaper_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned SAMPLE_W = 8
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       sample_now,
   input  logic [NUM_CH*CNT_W-1:0]    divider,
   input  logic [NUM_CH*CNT_W-1:0]    count,
   input  logic [NUM_CH*2-1:0]        mode,
   input  logic [NUM_CH-1:0]          ch_enable,
   output logic [NUM_CH*SAMPLE_W-1:0] sample,
   output logic [SAMPLE_W-1:0]        mix,
   output logic                       sample_valid,
   output logic                       busy,
   output logic                       overrun
);

   localparam int unsigned CH_W  = $clog2(NUM_CH);
   localparam int unsigned SUM_W = SAMPLE_W + CH_W;

   state_t               state_q, state_d;
   logic [CH_W-1:0]      ch_q, ch_d;
   logic [CNT_W-1:0]     div_q    [NUM_CH];
   logic [CNT_W-1:0]     cnt_q    [NUM_CH];
   wave_mode_t           mode_q   [NUM_CH];
   logic [NUM_CH-1:0]    en_q;
   logic [SAMPLE_W-1:0]  shadow_q [NUM_CH];

   logic [NUM_CH*SAMPLE_W-1:0] sample_q;
   logic [SAMPLE_W-1:0]        mix_q;
   logic                       valid_q, busy_q, overrun_q;

   logic                       accept_c, start_c, wr_c, commit_c, last_c, done_c;
   logic [SAMPLE_W-1:0]        wdata_c, quot_c;
   logic [SUM_W-1:0]           sum_c;
   logic [NUM_CH*SAMPLE_W-1:0] shadow_flat_c;

   frac_divider #(
      .CNT_W (CNT_W),
      .Q_W   (SAMPLE_W)
   ) u_div (
      .clk       (clk),
      .n_rst     (n_rst),
      .start_i   (start_c),
      .count_i   (cnt_q[ch_q]),
      .divider_i (div_q[ch_q]),
      .quot_o    (quot_c),
      .done_c_o  (done_c)
   );

   assign last_c = (ch_q == CH_W'(NUM_CH-1));

   // Next-state and per-cycle control for the channel walk.
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      accept_c = 1'b0;
      start_c  = 1'b0;
      wr_c     = 1'b0;
      commit_c = 1'b0;
      wdata_c  = SAMPLE_W'(MIDSCALE);
      case (state_q)
         IDLE: begin
            if (sample_now) begin
               accept_c = 1'b1;
               ch_d     = '0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            if (!en_q[ch_q]) begin
               wr_c    = 1'b1;
               state_d = last_c ? COMMIT : SETUP;
               ch_d    = last_c ? ch_q : ch_q + CH_W'(1);
            end else begin
               start_c = 1'b1;
               state_d = DIV;
            end
         end
         DIV: begin
            if (done_c) begin
               state_d = SHAPE;
            end
         end
         SHAPE: begin
            wr_c    = 1'b1;
            wdata_c = SAMPLE_W'(shape(mode_q[ch_q], PKG_SAMPLE_W'(quot_c)));
            state_d = last_c ? COMMIT : SETUP;
            ch_d    = last_c ? ch_q : ch_q + CH_W'(1);
         end
         COMMIT: begin
            commit_c = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Mixer sum and packed view of the shadow registers.
   always_comb begin
      sum_c         = '0;
      shadow_flat_c = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum_c = sum_c + SUM_W'(shadow_q[i]);
         shadow_flat_c[i*SAMPLE_W +: SAMPLE_W] = shadow_q[i];
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
      end
   end

   // Snapshot, shadow and committed output registers.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]    <= '0;
            cnt_q[i]    <= '0;
            mode_q[i]   <= SQUARE;
            shadow_q[i] <= '0;
         end
         en_q      <= '0;
         sample_q  <= '0;
         mix_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (accept_c) begin
            for (int i = 0; i < NUM_CH; i++) begin
               div_q[i]  <= divider[i*CNT_W +: CNT_W];
               cnt_q[i]  <= count[i*CNT_W +: CNT_W];
               mode_q[i] <= wave_mode_t'(mode[i*2 +: 2]);
            end
            en_q <= ch_enable;
         end
         if (wr_c) begin
            shadow_q[ch_q] <= wdata_c;
         end
         if (commit_c) begin
            sample_q <= shadow_flat_c;
            mix_q    <= SAMPLE_W'(sum_c >> CH_W);
         end
         valid_q   <= commit_c;
         busy_q    <= (state_d != IDLE);
         overrun_q <= sample_now && (state_q != IDLE);
      end
   end

   assign sample       = sample_q;
   assign mix          = mix_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_waveshaper_multi.sv
// Directed bench for waveshaper_multi with hand-computed expectations.
module tb_waveshaper_multi;

   localparam int unsigned NUM_CH   = 4;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned SAMPLE_W = 8;

   logic                       clk = 1'b0;
   logic                       n_rst;
   logic                       sample_now;
   logic [NUM_CH*CNT_W-1:0]    divider;
   logic [NUM_CH*CNT_W-1:0]    count;
   logic [NUM_CH*2-1:0]        mode;
   logic [NUM_CH-1:0]          ch_enable;
   logic [NUM_CH*SAMPLE_W-1:0] sample;
   logic [SAMPLE_W-1:0]        mix;
   logic                       sample_valid;
   logic                       busy;
   logic                       overrun;

   int n_vec = 0;
   int n_err = 0;

   waveshaper_multi #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .SAMPLE_W (SAMPLE_W)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .sample_now   (sample_now),
      .divider      (divider),
      .count        (count),
      .mode         (mode),
      .ch_enable    (ch_enable),
      .sample       (sample),
      .mix          (mix),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Test-1 configuration: all saw, all enabled, dividers 0x8000.
   task automatic cfg_default();
      count     = {16'h0000, 16'h7FFF, 16'h2000, 16'h4000};
      divider   = {4{16'h8000}};
      mode      = 8'h55;
      ch_enable = 4'hF;
   endtask

   // Pulse sample_now (accepted at edge 0) and return edges until sample_valid.
   task automatic run_frame(input bit scramble, output int lat);
      logic [NUM_CH*CNT_W-1:0] sc, sd;
      logic [NUM_CH*2-1:0]     sm;
      @(negedge clk);
      sample_now = 1'b1;
      @(posedge clk);
      #1;
      sample_now = 1'b0;
      sc = count;
      sd = divider;
      sm = mode;
      if (scramble) begin
         count   = ~count;
         divider = {4{16'h0003}};
         mode    = ~mode;
      end
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (sample_valid) break;
      end
      count   = sc;
      divider = sd;
      mode    = sm;
   endtask

   initial begin
      int lat;
      int ov_cnt;
      int v_cnt;
      logic [7:0] exp_mode [4];
      exp_mode[0] = 8'h00;
      exp_mode[1] = 8'h80;
      exp_mode[2] = 8'hFF;
      exp_mode[3] = 8'h7F;

      n_rst      = 1'b0;
      sample_now = 1'b0;
      cfg_default();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sample", sample, 32'h0);
      chk("rst_mix", 32'(mix), 32'h0);
      chk("rst_flags", 32'({sample_valid, busy, overrun}), 32'h0);
      @(negedge clk);
      n_rst = 1'b1;

      // 1: all saw; inputs scrambled after acceptance must not matter
      run_frame(1'b1, lat);
      chk("t1_lat", 32'(lat), 32'd41);
      chk("t1_sample", sample, 32'h00FF4080);
      chk("t1_mix", 32'(mix), 32'h6F);
      @(posedge clk);
      #1;
      chk("t1_valid_pulse", 32'(sample_valid), 32'h0);
      chk("t1_busy_idle", 32'(busy), 32'h0);

      // 2: ch0 each mode at scaled 0x80, then triangle at 0xC0
      for (int m = 0; m < 4; m++) begin
         cfg_default();
         mode[1:0] = 2'(m);
         run_frame(1'b0, lat);
         chk($sformatf("t2_mode%0d", m), 32'(sample[7:0]), 32'(exp_mode[m]));
      end
      cfg_default();
      count[15:0] = 16'h6000;
      mode[1:0]   = 2'b10;
      run_frame(1'b0, lat);
      chk("t2_tri_c0", 32'(sample[7:0]), 32'h7F);

      // 3: saturation via divider==0 and count>=divider
      cfg_default();
      divider[31:16] = 16'h0000;
      run_frame(1'b0, lat);
      chk("t3_div0_lat", 32'(lat), 32'd41);
      chk("t3_div0_ch1", 32'(sample[15:8]), 32'hFF);
      chk("t3_div0_mix", 32'(mix), 32'h9F);
      cfg_default();
      count[31:16] = 16'h9000;
      run_frame(1'b0, lat);
      chk("t3_big_lat", 32'(lat), 32'd41);
      chk("t3_big_ch1", 32'(sample[15:8]), 32'hFF);

      // 4: only ch2 enabled
      cfg_default();
      count[47:32] = 16'h2000;
      ch_enable    = 4'b0100;
      run_frame(1'b0, lat);
      chk("t4_lat", 32'(lat), 32'd14);
      chk("t4_sample", sample, 32'h80408080);
      chk("t4_mix", 32'(mix), 32'h70);

      // 5: re-pulses at edges 5 and 41 are dropped, edge 42 starts a new frame
      cfg_default();
      ov_cnt = 0;
      v_cnt  = 0;
      @(negedge clk);
      sample_now = 1'b1;
      @(posedge clk);
      #1;
      sample_now = 1'b0;
      for (int e = 1; e <= 90; e++) begin
         @(negedge clk);
         sample_now = (e == 5) || (e == 41) || (e == 42);
         @(posedge clk);
         #1;
         if (overrun) ov_cnt++;
         if (sample_valid) v_cnt++;
         if (e == 5)  chk("t5_ovr5", 32'(overrun), 32'h1);
         if (e == 40) chk("t5_busy40", 32'(busy), 32'h1);
         if (e == 41) begin
            chk("t5_ovr41", 32'(overrun), 32'h1);
            chk("t5_valid41", 32'(sample_valid), 32'h1);
            chk("t5_busy41", 32'(busy), 32'h0);
         end
         if (e == 42) chk("t5_busy42", 32'(busy), 32'h1);
         if (e == 83) chk("t5_valid83", 32'(sample_valid), 32'h1);
      end
      sample_now = 1'b0;
      chk("t5_ovr_count", 32'(ov_cnt), 32'd2);
      chk("t5_valid_count", 32'(v_cnt), 32'd2);

      // 6: reset at edge 20 aborts the frame
      v_cnt = 0;
      @(negedge clk);
      sample_now = 1'b1;
      @(posedge clk);
      #1;
      sample_now = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         if (e == 20) n_rst = 1'b0;
         @(posedge clk);
         #1;
         if (sample_valid) v_cnt++;
      end
      chk("t6_rst_sample", sample, 32'h0);
      chk("t6_rst_mix", 32'(mix), 32'h0);
      chk("t6_rst_flags", 32'({sample_valid, busy, overrun}), 32'h0);
      @(negedge clk);
      n_rst = 1'b1;
      for (int e = 0; e < 50; e++) begin
         @(posedge clk);
         #1;
         if (sample_valid) v_cnt++;
      end
      chk("t6_no_valid", 32'(v_cnt), 32'd0);
      run_frame(1'b0, lat);
      chk("t6_lat", 32'(lat), 32'd41);
      chk("t6_sample", sample, 32'h00FF4080);
      chk("t6_mix", 32'(mix), 32'h6F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
